// File: rtl/up_convert.sv
// up_convert: transmit up-conversion. Baseband I/Q samples are accepted once
// every R fast clocks, interpolated by R with a 2-stage CIC (linear
// interpolation), then mixed with a complex LO at the fast clock rate.
// Optional build macro: UPCONV_UNDERRUN_CNT_EN adds a saturating 16-bit
// count of missed input slots (underrun_cnt).
module up_convert #(
  parameter int IN_W  = 11,
  parameter int R     = 30,
  parameter int INT_W = 18,
  parameter int CIC_W = 16,
  parameter int OUT_W = 28
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [IN_W-1:0]  sig_baseband_real,
  input  logic signed [IN_W-1:0]  sig_baseband_imag,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [IN_W-1:0]  mod_Lo_real,
  input  logic signed [IN_W-1:0]  mod_Lo_imag,
  output logic signed [OUT_W-1:0] sig_mod_real,
  output logic signed [OUT_W-1:0] sig_mod_imag,
  output logic                    out_valid,
`ifdef UPCONV_UNDERRUN_CNT_EN
  output logic [15:0]             underrun_cnt,
`endif
  output logic                    underrun
);

  localparam int              PH_W    = $clog2(R);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(R - 1);

  logic [PH_W-1:0]         phase;
  logic                    started;
  logic [1:0]              valid_pipe;
  logic                    slot, accept, missed;

  logic signed [IN_W-1:0]  hold_r, hold_i;
  logic signed [IN_W-1:0]  h_sel_r, h_sel_i;
  logic signed [INT_W-1:0] h_d1_r, h_d1_i;
  logic signed [INT_W-1:0] c1_d1_r, c1_d1_i;
  logic signed [INT_W-1:0] c2_r, c2_i;
  logic signed [INT_W-1:0] c1_new_r, c1_new_i;
  logic signed [INT_W-1:0] c2_new_r, c2_new_i;
  logic signed [INT_W-1:0] stuff_r, stuff_i;
  logic signed [INT_W-1:0] i1_r, i1_i, i2_r, i2_i;
  logic signed [CIC_W-1:0] y_r, y_i;
  logic signed [OUT_W-1:0] yr_x, yi_x, lr_x, li_x;

  // The input slot is the last phase of each period; phase is cleared in
  // reset, so in_ready is low while reset is held.
  assign slot     = (phase == PH_LAST);
  assign in_ready = slot;
  assign accept   = slot & in_valid;
  assign missed   = slot & ~in_valid;

  // Comb-stage inputs, zero-stuffing and mixer operand sign extension.
  always_comb begin
    // NOTE: every output of a combinational block gets a value on every path
    // (here unconditionally), otherwise synthesis infers a latch.
    h_sel_r  = accept ? sig_baseband_real : hold_r;
    h_sel_i  = accept ? sig_baseband_imag : hold_i;
    c1_new_r = INT_W'(h_sel_r) - h_d1_r;
    c1_new_i = INT_W'(h_sel_i) - h_d1_i;
    c2_new_r = c1_new_r - c1_d1_r;
    c2_new_i = c1_new_i - c1_d1_i;
    stuff_r  = (phase == '0) ? c2_r : '0;
    stuff_i  = (phase == '0) ? c2_i : '0;
    y_r      = CIC_W'(i2_r);
    y_i      = CIC_W'(i2_i);
    yr_x     = OUT_W'(y_r);
    yi_x     = OUT_W'(y_i);
    lr_x     = OUT_W'(mod_Lo_real);
    li_x     = OUT_W'(mod_Lo_imag);
  end

  // Free-running slot phase counter, 0..R-1.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (!reset)    phase <= '0;
    else if (slot) phase <= '0;
    else           phase <= phase + 1'b1;
  end

  // Start tracking, sticky underrun, and the 3-edge output-valid delay.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      started    <= 1'b0;
      underrun   <= 1'b0;
      valid_pipe <= '0;
      out_valid  <= 1'b0;
    end else begin
      if (accept)             started  <= 1'b1;
      if (missed && started)  underrun <= 1'b1;
      valid_pipe <= {valid_pipe[0], started};
      out_valid  <= out_valid | valid_pipe[1];
    end
  end

`ifdef UPCONV_UNDERRUN_CNT_EN
  // Saturating count of slots missed after the stream has started.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      underrun_cnt <= '0;
    else if (missed && started && underrun_cnt != 16'hFFFF)
      underrun_cnt <= underrun_cnt + 16'd1;
  end
`endif

  // Hold register and comb section, advanced once per slot; a missed slot
  // re-enters the held sample so the output repeats instead of dropping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_r  <= '0;
      hold_i  <= '0;
      h_d1_r  <= '0;
      h_d1_i  <= '0;
      c1_d1_r <= '0;
      c1_d1_i <= '0;
      c2_r    <= '0;
      c2_i    <= '0;
    end else if (slot) begin
      hold_r  <= h_sel_r;
      hold_i  <= h_sel_i;
      h_d1_r  <= INT_W'(h_sel_r);
      h_d1_i  <= INT_W'(h_sel_i);
      c1_d1_r <= c1_new_r;
      c1_d1_i <= c1_new_i;
      c2_r    <= c2_new_r;
      c2_i    <= c2_new_i;
    end
  end

  // Two wrapping integrators at the fast rate.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      i1_r <= '0;
      i1_i <= '0;
      i2_r <= '0;
      i2_i <= '0;
    end else begin
      i1_r <= i1_r + stuff_r;
      i1_i <= i1_i + stuff_i;
      i2_r <= i2_r + i1_r;
      i2_i <= i2_i + i1_i;
    end
  end

  // Complex mixer, registered; LO is used directly at the product edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sig_mod_real <= '0;
      sig_mod_imag <= '0;
    end else begin
      sig_mod_real <= yr_x * lr_x - yi_x * li_x;
      sig_mod_imag <= yr_x * li_x + yi_x * lr_x;
    end
  end

endmodule

// File: tb/tb_up_convert.sv
// tb_up_convert: directed bench for up_convert. A per-edge reference built on
// the closed-form linear-interpolation response checks every cycle; a table of
// hand-computed steady-state outputs and hand sequences cover step, underrun,
// full-scale and reset corners.
module tb_up_convert;

  localparam int IN_W  = 11;
  localparam int R     = 30;
  localparam int INT_W = 18;
  localparam int CIC_W = 16;
  localparam int OUT_W = 28;

  logic                    clk = 1'b0;
  logic                    reset;
  logic signed [IN_W-1:0]  sig_baseband_real, sig_baseband_imag;
  logic                    in_valid;
  logic                    in_ready;
  logic signed [IN_W-1:0]  mod_Lo_real, mod_Lo_imag;
  logic signed [OUT_W-1:0] sig_mod_real, sig_mod_imag;
  logic                    out_valid;
  logic                    underrun;
`ifdef UPCONV_UNDERRUN_CNT_EN
  logic [15:0]             underrun_cnt;
`endif

  up_convert #(.IN_W(IN_W), .R(R), .INT_W(INT_W), .CIC_W(CIC_W), .OUT_W(OUT_W)) dut (
    .clk               (clk),
    .reset             (reset),
    .sig_baseband_real (sig_baseband_real),
    .sig_baseband_imag (sig_baseband_imag),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .mod_Lo_real       (mod_Lo_real),
    .mod_Lo_imag       (mod_Lo_imag),
    .sig_mod_real      (sig_mod_real),
    .sig_mod_imag      (sig_mod_imag),
    .out_valid         (out_valid),
`ifdef UPCONV_UNDERRUN_CNT_EN
    .underrun_cnt      (underrun_cnt),
`endif
    .underrun          (underrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference state: phase, the last three slot samples, edges since slot.
  int     m_ph, m_m, m_since, m_ucnt;
  bit     m_started, m_under;
  longint m_x0r, m_x1r, m_x2r, m_x0i, m_x1i, m_x2i;
  longint m_yr, m_yi;

  task automatic model_reset();
    m_ph = 0; m_m = 0; m_since = -1; m_ucnt = 0;
    m_started = 0; m_under = 0;
    m_x0r = 0; m_x1r = 0; m_x2r = 0; m_x0i = 0; m_x1i = 0; m_x2i = 0;
    m_yr = 0; m_yi = 0;
  endtask

  // Linear interpolation between consecutive slot samples, in edges since
  // the most recent slot edge.
  function automatic longint interp(input int m, input longint x2,
                                    input longint x1, input longint x0);
    if (m < 2) return (1 - m) * x2 + (m + R - 1) * x1;
    else       return (R + 1 - m) * x1 + (m - 1) * x0;
  endfunction

  // One clock: drive at the falling edge, advance reference at the rising
  // edge, compare all outputs at the next falling edge.
  task automatic tick(input bit v, input int ir, input int iq,
                      input int lr, input int li);
    longint er, ei;
    in_valid          = v;
    sig_baseband_real = IN_W'(ir);
    sig_baseband_imag = IN_W'(iq);
    mod_Lo_real       = IN_W'(lr);
    mod_Lo_imag       = IN_W'(li);
    er = m_yr * lr - m_yi * li;
    ei = m_yr * li + m_yi * lr;
    @(posedge clk);
    if (m_since >= 0) m_since++;
    if (m_ph == R - 1) begin
      if (v) begin
        if (!m_started) m_since = 0;
        m_started = 1;
      end else if (m_started) begin
        m_under = 1;
        if (m_ucnt < 65535) m_ucnt++;
      end
      m_x2r = m_x1r; m_x1r = m_x0r;
      m_x2i = m_x1i; m_x1i = m_x0i;
      if (v) begin m_x0r = ir; m_x0i = iq; end
      m_m = 0;
    end else begin
      m_m++;
    end
    m_yr = interp(m_m, m_x2r, m_x1r, m_x0r);
    m_yi = interp(m_m, m_x2i, m_x1i, m_x0i);
    m_ph = (m_ph + 1) % R;
    @(negedge clk);
    check("in_ready", in_ready, m_ph == R - 1);
    check("out_valid", out_valid, m_since >= 3);
    check("mod_real", sig_mod_real, er);
    check("mod_imag", sig_mod_imag, ei);
    check("underrun", underrun, m_under);
`ifdef UPCONV_UNDERRUN_CNT_EN
    check("underrun_cnt", underrun_cnt, m_ucnt);
`endif
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_real"}, sig_mod_real, 0);
    check({tag, "_imag"}, sig_mod_imag, 0);
    check({tag, "_underrun"}, underrun, 0);
`ifdef UPCONV_UNDERRUN_CNT_EN
    check({tag, "_cnt"}, underrun_cnt, 0);
`endif
  endtask

  // Idle ticks until in_ready; bounded so a dead DUT still ends the run.
  task automatic count_to_ready(output int n);
    n = 0;
    while (in_ready !== 1'b1 && n < 100) begin
      tick(0, 0, 0, 0, 0);
      n++;
    end
  endtask

  typedef struct {
    int     i, q, lr, li;
    longint exp_r, exp_i;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int     n;
    bit     alt;
    longint exp_step;

    vecs[0] = '{100,   0,     1023,  0,     64'sd3069000,  64'sd0};
    vecs[1] = '{0,     -1024, 0,     1023,  64'sd31426560, 64'sd0};
    vecs[2] = '{5,     -3,    2,     7,     64'sd930,      64'sd870};
    vecs[3] = '{-1024, 1023,  -1024, 1023,  64'sd61410,    -64'sd62853120};
    vecs[4] = '{1023,  -1024, 1023,  -1024, -64'sd61410,   -64'sd62853120};
    vecs[5] = '{-1,    -1,    1,     -1,    -64'sd60,      64'sd0};

    // Reset held with random inputs: everything stays at zero.
    model_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    sig_baseband_real = '0; sig_baseband_imag = '0;
    mod_Lo_real = '0; mod_Lo_imag = '0;
    #1 reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check_zero("rst_hold");
      in_valid          = 1'($urandom);
      sig_baseband_real = IN_W'($urandom);
      sig_baseband_imag = IN_W'($urandom);
      mod_Lo_real       = IN_W'($urandom);
      mod_Lo_imag       = IN_W'($urandom);
    end

    // Release: first slot after R-1 edges; a missed slot before start is
    // ignored; then the slot period is R.
    @(negedge clk);
    reset = 1'b1;
    count_to_ready(n);
    check("first_ready_cycle", n, R - 1);
    tick(0, 0, 0, 0, 0);
    check("underrun_prestart", underrun, 0);
    count_to_ready(n);
    check("ready_period", n + 1, R);

    // Step response: I=100, LO=(1023,0); ramp of 102300 per edge from E3.
    for (int j = 0; j <= 40; j++) begin
      tick(1, 100, 0, 1023, 0);
      exp_step = (j < 3) ? 0 : ((j - 2 > R) ? R : (j - 2)) * 64'sd102300;
      check("step_real", sig_mod_real, exp_step);
      check("step_imag", sig_mod_imag, 0);
      check("step_valid", out_valid, j >= 3);
    end
    check("underrun_before_gap", underrun, 0);

    // Two withheld slots: output holds flat and underrun sticks.
    for (int k = 0; k < 2 * R; k++) tick(0, 0, 0, 1023, 0);
    check("gap_real", sig_mod_real, 3069000);
    check("gap_underrun", underrun, 1);
`ifdef UPCONV_UNDERRUN_CNT_EN
    check("gap_cnt", underrun_cnt, 2);
`endif

    // Table: steady-state output for each constant sample / LO pair.
    for (int v = 0; v < 6; v++) begin
      for (int k = 0; k < 3 * R; k++) tick(1, vecs[v].i, vecs[v].q, vecs[v].lr, vecs[v].li);
      check($sformatf("vec%0d_real", v), sig_mod_real, vecs[v].exp_r);
      check($sformatf("vec%0d_imag", v), sig_mod_imag, vecs[v].exp_i);
    end

    // Full-scale alternation each slot, compared every edge.
    alt = 0;
    for (int k = 0; k < 12 * R; k++) begin
      if (m_ph == R - 1) alt = !alt;
      tick(1, alt ? 1023 : -1024, alt ? -1024 : 1023, 1023, -1024);
    end

    // Reset during a ramp at phase 12: outputs clear without a clock edge.
    n = 0;
    while ((m_ph != 12 || m_m > R) && n < 2 * R) begin
      tick(1, 500, -200, 700, 300);
      n++;
    end
    check("ramp_nonzero", sig_mod_real != 0, 1);
    reset = 1'b0;
    #1;
    check_zero("rst_async");
    model_reset();
    @(negedge clk);
    check_zero("rst_mid");
    @(negedge clk);
    reset = 1'b1;
    count_to_ready(n);
    check("restart_ready_cycle", n, R - 1);
    for (int k = 0; k < 40; k++) tick(1, 100, 0, 1023, 0);
    check("restart_real", sig_mod_real, 3069000);
    check("restart_underrun", underrun, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/up_convert.md
Name: up_convert

Overview:
- Transmit-side counterpart of the receive down-conversion chain.
- Takes complex baseband samples at 1/R of the fast clock rate and interpolates them by R with a 2-stage CIC, which performs linear interpolation.
- Mixes the interpolated stream with a complex LO to produce the modulated signal at the fast (480) rate.
- Single clock domain; the sample rate is set by a valid/ready slot every R cycles.

Parameters:
- IN_W, 11: baseband and LO sample width, signed.
- R, 30: interpolation factor, range 2..32.
- INT_W, 18: comb/integrator register width; arithmetic is two's-complement, wrapping modulo 2^INT_W.
- CIC_W, 16: CIC output width, taken as the low CIC_W bits of integrator 2 (exact, since |x|*R < 2^15).
- OUT_W, 28: mixer output width, equal to CIC_W+IN_W+1.

Ports:
- clk, in, 1: fast sample clock (480 rate).
- reset, in, 1: asynchronous, active-low reset.
- sig_baseband_real, in, IN_W: baseband I sample, signed.
- sig_baseband_imag, in, IN_W: baseband Q sample, signed.
- in_valid, in, 1: a baseband sample is offered.
- in_ready, out, 1: high only in the accept slot.
- mod_Lo_real, in, IN_W: LO cosine, signed.
- mod_Lo_imag, in, IN_W: LO sine, signed.
- sig_mod_real, out, OUT_W: modulated I, signed.
- sig_mod_imag, out, OUT_W: modulated Q, signed.
- out_valid, out, 1: outputs meaningful.
- underrun, out, 1: sticky flag, set when an accept slot is missed after start.

Behaviour:
- Reset (reset=0, asynchronous): all registers clear.
  - phase=0, started=0, underrun=0, out_valid=0.
  - sig_mod_*=0, hold register=0, comb delays=0, integrators=0.
  - Reset mid-operation aborts immediately; after release the block behaves exactly as after power-up.
- Phase counter: free-running 0..R-1, wraps R-1 -> 0.
- in_ready = (phase==R-1). It is combinational from phase and low during reset.
- Accept edge: the rising edge where in_valid & in_ready.
  - The hold register loads the sample.
  - started <= 1.
- Missed slot: phase==R-1 & !in_valid.
  - If started=1: hold register keeps its last sample (repeat) and underrun <= 1.
  - If started=0: no effect.
- Comb stage, updated at every phase==R-1 edge (whether or not the slot was used):
  - c1 = h - h_d1
  - c2 = c1 - c1_d1
  - Per-rail, INT_W wide; delay registers update at the same edge.
- Zero-stuff: the integrator-1 input is c2 during the cycle where phase==0; it is 0 in all other cycles.
- Integrators, updated every clock:
  - i1 <= i1 + stuff
  - i2 <= i2 + i1
  - Wrapping, INT_W wide.
- CIC out y = i2[CIC_W-1:0]. With a constant input x the steady state is R*x; a step ramps linearly over R cycles.
- Mixer, registered every clock:
  - sig_mod_real <= yr*Lr - yi*Li
  - sig_mod_imag <= yr*Li + yi*Lr
  - Full precision, sign-extended to OUT_W.
  - LO inputs are sampled at the same edge as the product register; no LO pipeline.
- Latency: the first i1 update occurs on the edge after the accept edge (E1).
  - i2 is updated at E2.
  - The product is registered at E3, so the first nonzero sig_mod appears after E3.
- out_valid rises at E3 after the first accept and stays 1 until reset.
- Simultaneous events: accept and wrap occur on the same edge by construction. A missed slot and an underrun set on the same edge is allowed; underrun never clears except by reset.

Optional Feature:
- Macro UPCONV_UNDERRUN_CNT_EN.
- Defined: adds output port underrun_cnt [15:0].
  - Increments on each missed slot while started=1.
  - Saturates at 16'hFFFF.
  - Reset value 0.
- Undefined: the port and counter are absent; the sticky underrun flag is unchanged.

Test Plan:
- Reset behaviour: hold reset=0, drive random inputs -> all outputs 0, in_ready=0. Release reset -> in_ready first high in cycle 29 (phase R-1), period 30.
- Step response:
  - Stimulus: present I=100, Q=0 at every slot; LO = (1023, 0).
  - out_valid rises 3 edges after the first accept.
  - sig_mod_real ramps 102300, 204600, ... reaching 3069000 after 30 samples and holding; sig_mod_imag stays 0.
- Quadrature mixing:
  - Stimulus: I=0, Q=-1024 steady; LO = (0, 1023).
  - Steady sig_mod_real = -(-30720*1023) = 31426560 (fits in OUT_W).
  - sig_mod_imag = 0.
- Underrun:
  - Stimulus: after steady I=100, withhold in_valid for 2 slots.
  - Output stays flat at 3069000 and underrun=1.
  - With UPCONV_UNDERRUN_CNT_EN, underrun_cnt=2.
  - Withholding before the first accept -> underrun stays 0.
- Full-scale extremes: alternate I = -1024 / +1023 each slot.
  - CIC output stays within ±30720 and never wraps visibly.
  - Output matches a golden CIC+mixer model bit-exactly.
- Reset mid-operation: assert reset at phase 12 during a ramp.
  - Outputs go 0 asynchronously (same cycle).
  - After release: clean restart, first in_ready at cycle 29.
